// File: rtl/square_pattern_gen.sv
// Square-wave stimulus source: after a start pulse emits CNT_NUM signed samples
// alternating between +amp and -amp, with a programmable half-period and optional slew limit.
module square_pattern_gen #(
  parameter int                   OUT_WIDTH = 18,
  parameter int                   CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0] CNT_NUM   = 32'd6000,
  parameter int unsigned          SLEW_STEP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] amp,
  input  logic [CNT_WIDTH-1:0] half_period,
  input  logic                 init_high,
  output logic [OUT_WIDTH-1:0] dat,
  output logic                 dat_valid,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 done,
  output logic                 state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_NUM - 1'b1;
  localparam logic [OUT_WIDTH-1:0] AMP_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH:0]   STEP     = (OUT_WIDTH+1)'(SLEW_STEP);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   phase_q, phase_d;
  logic [CNT_WIDTH-1:0]   edge_q, edge_d;
  logic [CNT_WIDTH-1:0]   hp_q, hp_d;
  logic [OUT_WIDTH-1:0]   amp_q, amp_d;
  logic [OUT_WIDTH-1:0]   dat_q, dat_d;
  logic                   level_q, level_d;
  logic                   done_d;
  logic                   done_q;

  logic [OUT_WIDTH-1:0]   origin;
  logic [OUT_WIDTH:0]     origin_x;
  logic [OUT_WIDTH:0]     target;
  logic [OUT_WIDTH:0]     diff;
  logic [OUT_WIDTH:0]     abs_diff;
  logic [OUT_WIDTH:0]     step_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      edge_q  <= '0;
      hp_q    <= '0;
      amp_q   <= '0;
      dat_q   <= '0;
      level_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      edge_q  <= edge_d;
      hp_q    <= hp_d;
      amp_q   <= amp_d;
      dat_q   <= dat_d;
      level_q <= level_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    edge_d  = edge_q;
    hp_d    = hp_q;
    amp_d   = amp_q;
    level_d = level_q;
    done_d  = 1'b0;
    origin  = dat_q;

    if (start) begin
      // A start in RUN (even on the last sample) restarts and suppresses done.
      state_d = RUN;
      cnt_d   = '0;
      phase_d = '0;
      edge_d  = '0;
      level_d = init_high;
      amp_d   = (amp > AMP_MAX) ? AMP_MAX : amp;
      hp_d    = (half_period == '0) ? ONE_CNT : half_period;
      origin  = '0;
    end else if (state_q == RUN) begin
      if (cnt_q == LAST_CNT) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (phase_q == hp_q - 1'b1) begin
          level_d = ~level_q;
          phase_d = '0;
          edge_d  = edge_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end

    // Next sample is one slew step from the current one toward the next level's target.
    origin_x = {origin[OUT_WIDTH-1], origin};
    target   = level_d ? {1'b0, amp_d} : -{1'b0, amp_d};
    diff     = target - origin_x;
    abs_diff = diff[OUT_WIDTH] ? -diff : diff;
    if (STEP == '0 || abs_diff <= STEP) begin
      step_val = target;
    end else if (diff[OUT_WIDTH]) begin
      step_val = origin_x - STEP;
    end else begin
      step_val = origin_x + STEP;
    end
    dat_d = (state_d == RUN) ? step_val[OUT_WIDTH-1:0] : '0;
  end

  assign dat       = dat_q;
  assign dat_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign edge_cnt  = edge_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_square_pattern_gen.sv
// Randomized bench for square_pattern_gen: an instantaneous-step and a slew-limited
// instance share stimulus and are checked sample by sample against a level/slew model.
module tb_square_pattern_gen;

  localparam int W    = 18;
  localparam int CW   = 32;
  localparam int N    = 6000;
  localparam int SLEW = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  amp;
  logic [CW-1:0] half_period;
  logic          init_high;

  logic [W-1:0]  dat0, dat1;
  logic          dat_valid0, dat_valid1;
  logic          busy0, busy1;
  logic [CW-1:0] edge0, edge1;
  logic          done0, done1;
  logic          st0, st1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  longint       hp_eff;

  always #5 clk = ~clk;

  square_pattern_gen #(.OUT_WIDTH(W), .CNT_WIDTH(CW), .CNT_NUM(N), .SLEW_STEP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .amp(amp), .half_period(half_period),
    .init_high(init_high), .dat(dat0), .dat_valid(dat_valid0), .busy(busy0),
    .edge_cnt(edge0), .done(done0), .state_dbg(st0)
  );

  square_pattern_gen #(.OUT_WIDTH(W), .CNT_WIDTH(CW), .CNT_NUM(N), .SLEW_STEP(SLEW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .amp(amp), .half_period(half_period),
    .init_high(init_high), .dat(dat1), .dat_valid(dat_valid1), .busy(busy1),
    .edge_cnt(edge1), .done(done1), .state_dbg(st1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole window computed from the level rule (k / hp parity) and a clamped slew walk.
  task automatic build_model(input logic [W-1:0] a, input logic [CW-1:0] hp, input logic ih);
    longint amp_s, tgt, d, p1;
    logic   lvl;
    exp_q0.delete();
    exp_q1.delete();
    amp_s  = (a > 131071) ? 131071 : longint'(a);
    hp_eff = (hp == 0) ? 1 : longint'(hp);
    p1     = 0;
    for (int k = 0; k < N; k++) begin
      lvl = ih ^ (((k / hp_eff) % 2) == 1);
      tgt = lvl ? amp_s : -amp_s;
      exp_q0.push_back(W'(tgt));
      d = tgt - p1;
      if (d > SLEW)       p1 = p1 + SLEW;
      else if (d < -SLEW) p1 = p1 - SLEW;
      else                p1 = tgt;
      exp_q1.push_back(W'(p1));
    end
  endtask

  task automatic start_run(input logic [W-1:0] a, input logic [CW-1:0] hp, input logic ih);
    amp         = a;
    half_period = hp;
    init_high   = ih;
    start       = 1'b1;
    build_model(a, hp, ih);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks n window samples; leaves time at the negedge of the last one checked.
  task automatic check_samples(input int n);
    for (int k = 0; k < n; k++) begin
      check("dat0", dat0, exp_q0.pop_front());
      check("dat1", dat1, exp_q1.pop_front());
      check("valid0", dat_valid0, 1);
      check("valid1", dat_valid1, 1);
      check("busy0", busy0, 1);
      check("edge0", edge0, k / hp_eff);
      check("edge1", edge1, k / hp_eff);
      check("done_in_run", done0 | done1, 0);
      amp         = W'($urandom);
      half_period = $urandom_range(0, 7);
      init_high   = 1'($urandom_range(0, 1));
      if (k < n - 1) @(negedge clk);
    end
  endtask

  task automatic finish_window();
    @(negedge clk);
    check("done0", done0, 1);
    check("done1", done1, 1);
    check("end_dat0", dat0, 0);
    check("end_dat1", dat1, 0);
    check("end_valid0", dat_valid0, 0);
    check("end_busy1", busy1, 0);
    check("final_edge0", edge0, (N - 1) / hp_eff);
    check("final_edge1", edge1, (N - 1) / hp_eff);
    @(negedge clk);
    check("done_pulse0", done0, 0);
    check("done_pulse1", done1, 0);
    check("hold_edge0", edge0, (N - 1) / hp_eff);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dat0"}, dat0, 0);
    check({tag, "_dat1"}, dat1, 0);
    check({tag, "_valid0"}, dat_valid0, 0);
    check({tag, "_valid1"}, dat_valid1, 0);
    check({tag, "_busy0"}, busy0, 0);
    check({tag, "_busy1"}, busy1, 0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_done1"}, done1, 0);
    check({tag, "_edge0"}, edge0, 0);
    check({tag, "_edge1"}, edge1, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    amp         = '0;
    half_period = '0;
    init_high   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // Baseline: 100-sample half-period, 59 edges
    start_run(18'd1000, 32'd100, 1'b1);
    check_samples(N);
    finish_window();
    repeat (3) @(negedge clk);

    // Half-period 0 treated as 1: toggles every sample
    start_run(18'd1000, 32'd0, 1'b1);
    check_samples(N);
    finish_window();

    // Saturated amplitude, starting low
    start_run(18'h3FFFF, $urandom_range(1, 200), 1'b0);
    check_samples(N);
    finish_window();

    // Random configuration
    start_run(W'($urandom), $urandom_range(1, 400), 1'($urandom_range(0, 1)));
    check_samples(N);
    finish_window();

    // Restart at window sample 2500
    start_run(W'($urandom_range(0, 5000)), $urandom_range(1, 300), 1'b1);
    check_samples(2501);
    start_run(W'($urandom), $urandom_range(1, 300), 1'($urandom_range(0, 1)));
    check_samples(N);
    finish_window();

    // Start on the last sample suppresses done and restarts
    start_run(W'($urandom), $urandom_range(1, 50), 1'b0);
    check_samples(N);
    start_run(18'd2000, 32'd7, 1'b1);
    check_samples(N);
    finish_window();

    // Asynchronous reset at window sample 3000
    start_run(W'($urandom), $urandom_range(1, 300), 1'b1);
    check_samples(3001);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done0 | done1, 0);
      check("idle_after_rst", busy0 | busy1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/square_pattern_gen.md
# square_pattern_gen

Programmable square-wave stimulus source for the demodulation datapath: the transmit-side counterpart of the square-wave judge. After a one-cycle `start` pulse it emits exactly `CNT_NUM` signed samples alternating between +amp and −amp, with a programmable half-period and an optional slew limit. The slew limit shapes edge steepness, so downstream edge thresholds and minimum-edge-spacing logic can be exercised in-system.

## Interface
- `OUT_WIDTH`, 18 — sample width, two's complement.
- `CNT_WIDTH`, 32 — width of the window, phase and edge counters.
- `CNT_NUM`, 32'd6000 — samples per run window.
- `SLEW_STEP`, 0 — maximum |Δdat| per cycle, unsigned; 0 means an instantaneous step.

Ports:
- `clk`  in  1  — system clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — one-cycle run request; samples the configuration inputs.
- `amp`  in  OUT_WIDTH  — unsigned magnitude.
- `half_period`  in  CNT_WIDTH  — samples per level.
- `init_high`  in  1  — first level is +amp when 1, −amp when 0.
- `dat`  out  OUT_WIDTH  — signed sample.
- `dat_valid`  out  1  — high for each of the CNT_NUM window samples.
- `busy`  out  1  — high while in RUN.
- `edge_cnt`  out  CNT_WIDTH  — level toggles emitted in the current or last run.
- `done`  out  1  — one-cycle end-of-window pulse.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN on `start`.
  - RUN → IDLE when the window counter `cnt` reaches CNT_NUM−1.
  - `start` in RUN restarts the run immediately.
- Configuration capture on `start`:
  - `amp_r = min(amp, 2^(OUT_WIDTH−1)−1)`.
  - `hp_r = max(half_period, 1)`.
  - `level = init_high`.
  - `cnt`, `phase_cnt` and `edge_cnt` are cleared.
  - `dat` is reset to 0 as the slew origin.
- Each RUN cycle:
  - target = level ? +amp_r : −amp_r.
  - d = target − dat, computed at OUT_WIDTH+1 bits signed.
  - If SLEW_STEP = 0 or |d| ≤ SLEW_STEP: dat ← target.
  - Else: dat ← dat ± SLEW_STEP, sign of d.
- Level sequencing:
  - `phase_cnt` counts samples at the current level.
  - When `phase_cnt == hp_r−1` and the window is not ending: level toggles, `phase_cnt ← 0`, `edge_cnt ← edge_cnt+1`.
  - The new level's target applies from the next sample.
- Window: `cnt` increments once per emitted sample. The sample with `cnt == CNT_NUM−1` is the last.
- In IDLE:
  - `dat = 0`, `dat_valid = 0`, `busy = 0`.
  - `edge_cnt` holds its final value until the next `start`.

## Timing
- Reset values:
  - `dat = 0`, `dat_valid = 0`, `busy = 0`, `done = 0`, `edge_cnt = 0`.
  - State IDLE; all internal counters 0.
- Latency:
  - `start` in cycle T → first valid sample in cycle T+1.
  - That sample is the first slew step from 0 toward the initial target.
  - `dat_valid` is high for cycles T+1 … T+CNT_NUM.
- `done` is high in cycle T+CNT_NUM+1. In that same cycle:
  - `dat_valid`, `busy` and `dat` have returned to 0/IDLE.
  - `edge_cnt` is final.
- Toggles: the first sample of the opposite level is window sample index hp_r, then every hp_r samples after that. Final edge count = ⌈CNT_NUM/hp_r⌉ − 1.
- Restart mid-run:
  - `start` in RUN at cycle S → a fresh window from cycle S+1; `edge_cnt` reads 0 at S+1.
  - No `done` is emitted for the aborted window.
  - `start` in the same cycle that would assert `done` also suppresses `done` and restarts.
- Configuration inputs are ignored except in the `start` cycle.
- `rst_n` asserted mid-run → all outputs go to reset values immediately (asynchronous). No `done` is emitted after release.

## Test plan
- Baseline:
  - Stimulus: amp=1000, half_period=100, init_high=1, SLEW_STEP=0, CNT_NUM=6000.
  - Samples 0–99 = +1000, samples 100–199 = −1000, and alternating after that.
  - `dat_valid` is high for exactly 6000 cycles; `done` fires once, one cycle after the last sample; `edge_cnt` = 59.
- Slew:
  - Stimulus: SLEW_STEP=300, amp=1000, init_high=1.
  - First samples are 300, 600, 900, 1000.
  - After the first toggle: 700, 400, 100, −200, −500, −800, −1000.
- Minimum period:
  - Stimulus: half_period=0.
  - The output toggles every sample (treated as 1); `edge_cnt` = 5999.
- Saturation:
  - Stimulus: amp=18'h3FFFF, init_high=0.
  - Samples are −131071 / +131071; no wrap occurs.
- Restart and reset:
  - `start` at window sample 2500 → `edge_cnt` clears and a new 6000-sample window follows, with a single `done`.
  - `rst_n` low at sample 3000 → outputs are 0 within the same cycle, and no `done` is emitted after release.
